// File: rtl/ercm8_sched.sv
// ercm8_sched: round-robin scheduler feeding four requesters into one shared
// ERCM8 multiplier through a two-stage operand/response pipeline.
module ercm8_sched #(
    parameter logic [6:0] MASK_RST = 7'h00,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req_valid,
    output logic [3:0]       req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_id,
    input  logic [6:0]       cfg_mask,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    output logic [6:0]       mul_mask,
    input  logic [15:0]      mul_p,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_id,
    output logic [15:0]      rsp_dat,
    output logic [CNT_W-1:0] op_cnt
);
    logic [1:0]       r_ptr;
    logic [6:0]       r_mask [4];
    logic             r_s1_v;
    logic [1:0]       r_s1_id;
    logic [7:0]       r_mul_a;
    logic [7:0]       r_mul_b;
    logic [6:0]       r_mul_mask;
    logic             r_s2_v;
    logic [1:0]       r_rsp_id;
    logic [15:0]      r_rsp_dat;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s2_load;
    logic             w_s1_load;
    logic             w_gnt_v;
    logic [1:0]       w_gnt_id;
    logic             w_acc;

    assign w_s2_load = !r_s2_v || rsp_ready;
    assign w_s1_load = !r_s1_v || w_s2_load;
    assign w_acc     = w_gnt_v && w_s1_load;

    // Search starts just after the last grant so every requester gets a turn.
    always_comb begin
        w_gnt_v  = 1'b0;
        w_gnt_id = r_ptr;
        for (int k = 1; k <= 4; k++) begin
            if (!w_gnt_v && req_valid[r_ptr + 2'(k)]) begin
                w_gnt_v  = 1'b1;
                w_gnt_id = r_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        req_ready = 4'b0000;
        if (w_acc && !rst) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= 2'd3;
            for (int i = 0; i < 4; i++) begin
                r_mask[i] <= MASK_RST;
            end
            r_s1_v     <= 1'b0;
            r_s1_id    <= 2'd0;
            r_mul_a    <= 8'd0;
            r_mul_b    <= 8'd0;
            r_mul_mask <= 7'd0;
            r_s2_v     <= 1'b0;
            r_rsp_id   <= 2'd0;
            r_rsp_dat  <= 16'd0;
            r_cnt      <= '0;
        end else begin
            if (cfg_we) begin
                r_mask[cfg_id] <= cfg_mask;
            end
            if (w_s1_load) begin
                r_s1_v <= w_acc;
            end
            // Mask is read before this edge's cfg write lands.
            if (w_acc) begin
                r_ptr      <= w_gnt_id;
                r_s1_id    <= w_gnt_id;
                r_mul_a    <= req_a[8*w_gnt_id +: 8];
                r_mul_b    <= req_b[8*w_gnt_id +: 8];
                r_mul_mask <= r_mask[w_gnt_id];
            end
            if (w_s2_load) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_rsp_id  <= r_s1_id;
                    r_rsp_dat <= mul_p;
                end
            end
            if (r_s2_v && rsp_ready) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign mul_mask  = r_mul_mask;
    assign rsp_valid = r_s2_v;
    assign rsp_id    = r_rsp_id;
    assign rsp_dat   = r_rsp_dat;
    assign op_cnt    = r_cnt;
endmodule
